// File: rtl/msb_serializer.sv
// MSB-first parallel-to-serial converter with an optional idle gap after each word.
// A word is accepted on an in_valid/in_ready handshake. Its bits then appear on dout
// over WIDTH consecutive cycles, with dout_first marking the MSB and dout_last the LSB.
module msb_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_first,
  output logic             dout_last,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);
  // GAP-1 is only loaded when GAP > 0; this guard keeps the constant in range.
  localparam logic [3:0] GapLoad = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic NoGap = (GAP == 0);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CntW-1:0]  cnt_q;
  logic [3:0]       gcnt_q;

  logic in_shift;
  logic last_bit;

  assign in_shift = (state_q == StShift);
  assign last_bit = in_shift && (cnt_q == '0);

  // Outputs decode directly from registered state, so they are free of input paths
  // except in_ready, which is a function of state only as well.
  always_comb begin
    in_ready   = (state_q == StIdle) || (last_bit && NoGap);
    dout       = in_shift && shreg_q[WIDTH-1];
    dout_valid = in_shift;
    dout_first = in_shift && (cnt_q == CntMax);
    dout_last  = last_bit;
    busy       = (state_q != StIdle);
  end

  // FSM, shift register, bit counter and gap counter; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            shreg_q <= in_data;
            cnt_q   <= CntMax;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (cnt_q == '0) begin
            if (NoGap) begin
              if (in_valid) begin
                // Back-to-back reload: next word's MSB follows with no bubble.
                shreg_q <= in_data;
                cnt_q   <= CntMax;
                state_q <= StShift;
              end else begin
                shreg_q <= shreg_q << 1;
                state_q <= StIdle;
              end
            end else begin
              shreg_q <= shreg_q << 1;
              gcnt_q  <= GapLoad;
              state_q <= StGap;
            end
          end else begin
            shreg_q <= shreg_q << 1;
            cnt_q   <= cnt_q - 1'b1;
          end
        end
        StGap: begin
          if (gcnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            gcnt_q <= gcnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msb_serializer.sv
// Scoreboard bench for msb_serializer: one instance with GAP=0 and one with GAP=2.
// Expected bits are queued at each handshake and popped whenever dout_valid is seen.
module tb_msb_serializer;

  typedef struct packed {
    logic d;
    logic f;
    logic l;
  } exp_t;

  logic clk;
  logic reset;

  logic [7:0] in_data0, in_data1;
  logic in_valid0, in_valid1;
  logic in_ready0, in_ready1;
  logic dout0, dout1, dout_valid0, dout_valid1;
  logic dout_first0, dout_first1, dout_last0, dout_last1;
  logic busy0, busy1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   vcnt0 = 0;
  bit   mon_en = 0;

  msb_serializer #(.WIDTH(8), .GAP(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data0),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .dout      (dout0),
    .dout_valid(dout_valid0),
    .dout_first(dout_first0),
    .dout_last (dout_last0),
    .busy      (busy0)
  );

  msb_serializer #(.WIDTH(8), .GAP(2)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .dout      (dout1),
    .dout_valid(dout_valid1),
    .dout_first(dout_first1),
    .dout_last (dout_last1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Offer a word; handshake happens on the first edge where in_ready is seen high.
  task automatic send0(input logic [7:0] w);
    bit ok = 0;
    in_data0  = w;
    in_valid0 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("send0_timeout", 0, 1);
    else for (int b = 7; b >= 0; b--) q0.push_back('{w[b], b == 7, b == 0});
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] w);
    bit ok = 0;
    in_data1  = w;
    in_valid1 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("send1_timeout", 0, 1);
    else for (int b = 7; b >= 0; b--) q1.push_back('{w[b], b == 7, b == 0});
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // Output monitors: every live bit must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (dout_valid0 === 1'b1) begin
        vcnt0++;
        if (q0.size() == 0) check("d0_unexpected_bit", 1, 0);
        else begin
          e = q0.pop_front();
          check("d0_bit", dout0, e.d);
          check("d0_first", dout_first0, e.f);
          check("d0_last", dout_last0, e.l);
        end
      end else begin
        check("d0_quiet", {dout_valid0, dout0, dout_first0, dout_last0}, 0);
      end
      if (dout_valid1 === 1'b1) begin
        if (q1.size() == 0) check("d1_unexpected_bit", 1, 0);
        else begin
          e = q1.pop_front();
          check("d1_bit", dout1, e.d);
          check("d1_first", dout_first1, e.f);
          check("d1_last", dout_last1, e.l);
        end
      end else begin
        check("d1_quiet", {dout_valid1, dout1, dout_first1, dout_last1}, 0);
      end
    end
  end

  initial begin
    int v_start;
    bit seen;
    reset     = 1'b1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_data0  = '0;
    in_data1  = '0;
    cycles(2);
    reset  = 1'b0;
    mon_en = 1;

    // Reset state.
    check("rst_ready0", in_ready0, 1);
    check("rst_busy0", busy0, 0);
    check("rst_valid0", {dout_valid0, dout0, dout_first0, dout_last0}, 0);
    check("rst_ready1", in_ready1, 1);
    check("rst_busy1", busy1, 0);

    // Single word, first bit in the cycle right after the handshake.
    send0(8'hA5);
    check("a5_lat_valid", dout_valid0, 1);
    check("a5_lat_first", dout_first0, 1);
    cycles(8);
    check("a5_idle_busy", busy0, 0);
    check("a5_idle_ready", in_ready0, 1);

    // Back-to-back words with no bubble: 16 contiguous live cycles.
    send0(8'h0F);
    v_start = vcnt0;
    send0(8'hF0);
    cycles(8);
    check("b2b_contig", vcnt0 - v_start, 16);
    check("b2b_idle", busy0, 0);

    // Offer 8'hFF during a word in flight: ignored until the last-bit cycle.
    send0(8'h00);
    in_data0  = 8'hFF;
    in_valid0 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("hold_not_ready", in_ready0, 0);
      @(posedge clk);
      #1;
    end
    check("hold_last_ready", in_ready0, 1);
    send0(8'hFF);
    cycles(8);

    // Reset after three bits of 8'hC3 drops the partial word.
    send0(8'hC3);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    q0.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_valid", dout_valid0, 0);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_ready", in_ready0, 1);
    send0(8'h81);
    cycles(8);

    // Reset and handshake in the same cycle: no capture.
    in_data0  = 8'hAA;
    in_valid0 = 1'b1;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid0 = 1'b0;
    check("rst_hs_busy", busy0, 0);
    check("rst_hs_ready", in_ready0, 1);
    cycles(3);
    check("rst_hs_still_idle", busy0, 0);

    // GAP=2: two gap cycles, one idle cycle, then the second word.
    send1(8'h19);
    in_data1  = 8'h05;
    in_valid1 = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dout_last1 === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("gap_saw_last", seen, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("gap_valid", dout_valid1, 0);
      check("gap_ready", in_ready1, 0);
      check("gap_busy", busy1, 1);
    end
    @(negedge clk);
    check("gap_idle_ready", in_ready1, 1);
    check("gap_idle_busy", busy1, 0);
    send1(8'h05);
    check("gap_w2_first", dout_first1, 1);
    cycles(12);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
